// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-select encoding used by the ALU and its issue sequencer,
// plus the sequencer's FSM state type.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of the request handshake, ALU operand/result bus and result handshake
// seen by alu_op_sequencer; slave is the sequencer's view, master the environment's.
interface alu_op_sequencer_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [1:0]       in_op;
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [1:0]       alu_op;
    logic [N-1:0]     alu_result;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_result;
    logic             out_zero;
    logic             out_neg;
    logic             out_carry;
    logic             out_ovf;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  in_valid, in_a, in_b, in_op, alu_result, out_ready,
        output in_ready, alu_a, alu_b, alu_op, out_valid, out_result,
               out_zero, out_neg, out_carry, out_ovf, op_count
    );

    modport master (
        output in_valid, in_a, in_b, in_op, alu_result, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result,
               out_zero, out_neg, out_carry, out_ovf, op_count
    );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational status-flag derivation for the ALU: zero, negative, carry/borrow and
// signed overflow, computed from the operands, op select and the ALU's result.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    input  logic [N-1:0] result,
    output logic         zero,
    output logic         neg,
    output logic         carry,
    output logic         ovf
);

    logic [N:0]          sum_ext;
    logic signed [N-1:0] a_s;
    logic signed [N-1:0] b_s;
    logic signed [N-1:0] r_s;

    assign a_s = signed'(a);
    assign b_s = signed'(b);
    assign r_s = signed'(result);

    always_comb begin
        sum_ext = {1'b0, a} + {1'b0, b};
        zero    = (result == '0);
        neg     = r_s[N-1];
        carry   = 1'b0;
        ovf     = 1'b0;
        case (op)
            ALU_ADD: begin
                carry = sum_ext[N];
                ovf   = (a_s[N-1] == b_s[N-1]) && (r_s[N-1] != a_s[N-1]);
            end
            ALU_SUB: begin
                // Borrow is the unsigned compare, independent of the result bits.
                carry = (a < b);
                ovf   = (a_s[N-1] != b_s[N-1]) && (r_s[N-1] != a_s[N-1]);
            end
            default: begin
                carry = 1'b0;
                ovf   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the two-operand ALU: registers requests onto the ALU inputs, captures
// the result with derived flags one cycle later, and holds it until downstream accepts.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  bus
);

    seq_state_t       state;
    logic [N-1:0]     alu_a_q;
    logic [N-1:0]     alu_b_q;
    logic [1:0]       alu_op_q;
    logic [N-1:0]     result_q;
    logic             zero_q;
    logic             neg_q;
    logic             carry_q;
    logic             ovf_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] op_count_q;

    logic             zero_c;
    logic             neg_c;
    logic             carry_c;
    logic             ovf_c;
    logic             accept;

    alu_flag_gen #(.N(N)) u_flag_gen (
        .a      (alu_a_q),
        .b      (alu_b_q),
        .op     (alu_op_q),
        .result (bus.alu_result),
        .zero   (zero_c),
        .neg    (neg_c),
        .carry  (carry_c),
        .ovf    (ovf_c)
    );

    // DONE hands in_ready straight through from out_ready so a new op can issue
    // in the same cycle the previous result retires.
    assign bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept       = bus.in_ready && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= ALU_ADD;
            result_q    <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a_q  <= bus.in_a;
                        alu_b_q  <= bus.in_b;
                        alu_op_q <= bus.in_op;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    result_q    <= bus.alu_result;
                    zero_q      <= zero_c;
                    neg_q       <= neg_c;
                    carry_q     <= carry_c;
                    ovf_q       <= ovf_c;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 1'b1;
                        if (bus.in_valid) begin
                            alu_a_q  <= bus.in_a;
                            alu_b_q  <= bus.in_b;
                            alu_op_q <= bus.in_op;
                            state    <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_neg    = neg_q;
    assign bus.out_carry  = carry_q;
    assign bus.out_ovf    = ovf_q;
    assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural 4-bit ALU attached and an
// integer-arithmetic reference model for result and flags.
module tb_alu_op_sequencer;

    localparam int N     = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   exp_count = 0;

    alu_op_sequencer_if #(.N(N), .CNT_W(CNT_W)) bus ();

    alu_op_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // The ALU itself: plain combinational function of the registered operands.
    always_comb begin
        case (bus.alu_op)
            2'b00:   bus.alu_result = bus.alu_a + bus.alu_b;
            2'b01:   bus.alu_result = bus.alu_a - bus.alu_b;
            2'b10:   bus.alu_result = bus.alu_a & bus.alu_b;
            default: bus.alu_result = bus.alu_a | bus.alu_b;
        endcase
    end

    // Reference: returns {R[3:0], zero, neg, carry, ovf} from integer arithmetic.
    function automatic logic [7:0] ref_op(input int a, input int b, input int op);
        int sa, sb, u, s, r;
        logic z, n, c, o;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        c = 1'b0;
        o = 1'b0;
        case (op)
            0: begin
                u = a + b; r = u % 16; c = (u > 15);
                s = sa + sb; o = (s > 7) || (s < -8);
            end
            1: begin
                u = a - b; r = (u + 16) % 16; c = (a < b);
                s = sa - sb; o = (s > 7) || (s < -8);
            end
            2: r = a & b;
            default: r = a | b;
        endcase
        z = (r == 0);
        n = (r >= 8);
        return {r[3:0], z, n, c, o};
    endfunction

    function automatic logic [7:0] observed();
        return {bus.out_result, bus.out_zero, bus.out_neg, bus.out_carry, bus.out_ovf};
    endfunction

    logic [3:0] d_a   [6] = '{4'h7, 4'h9, 4'h3, 4'h5, 4'hC, 4'hC};
    logic [3:0] d_b   [6] = '{4'h3, 4'h8, 4'h5, 4'h5, 4'h3, 4'h3};
    logic [1:0] d_op  [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
    logic [7:0] d_exp [6] = '{8'hA5, 8'h13, 8'hE6, 8'h08, 8'h08, 8'hF4};

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_count = 0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.alu_a !== 4'h0 || bus.alu_b !== 4'h0 || bus.alu_op !== 2'b00) begin
            errors++;
            $display("FAIL reset_alu_regs: a=%h b=%h op=%h, required 0 0 0", bus.alu_a, bus.alu_b, bus.alu_op);
        end
        checks++;
        if (observed() !== 8'h00 || bus.op_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: flags=%h count=%0d, required 00 0", observed(), bus.op_count);
        end
    endtask

    task automatic test_directed();
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1; bus.in_a = d_a[i]; bus.in_b = d_b[i]; bus.in_op = d_op[i];
            bus.out_ready = 1'b0;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_in_ready: got %b, required 1", i, bus.in_ready);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
                {bus.alu_a, bus.alu_b, bus.alu_op} !== {d_a[i], d_b[i], d_op[i]}) begin
                errors++;
                $display("FAIL dir%0d_exec: out_valid=%b in_ready=%b alu=%h/%h/%h, required 0 0 %h/%h/%h",
                         i, bus.out_valid, bus.in_ready, bus.alu_a, bus.alu_b, bus.alu_op, d_a[i], d_b[i], d_op[i]);
            end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || observed() !== d_exp[i]) begin
                errors++;
                $display("FAIL dir%0d_result: valid=%b {R,z,n,c,o}=%h, required 1 %h", i, bus.out_valid, observed(), d_exp[i]);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            exp_count++;
            checks++;
            if (bus.op_count !== exp_count[7:0] || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_count: count=%0d valid=%b, required %0d 0", i, bus.op_count, bus.out_valid, exp_count);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] ra, rb;
        logic [1:0] rop;
        logic [7:0] exp;
        for (int i = 0; i < 24; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rop = 2'($urandom_range(0, 3));
            exp = ref_op(int'(ra), int'(rb), int'(rop));
            bus.in_valid = 1'b1; bus.in_a = ra; bus.in_b = rb; bus.in_op = rop;
            @(negedge clk);
            bus.in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || observed() !== exp) begin
                errors++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: valid=%b got %h, required 1 %h",
                         i, rop, ra, rb, bus.out_valid, observed(), exp);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            exp_count++;
            checks++;
            if (bus.op_count !== exp_count[7:0] || bus.alu_a !== ra || bus.alu_b !== rb) begin
                errors++;
                $display("FAIL rand%0d_idle: count=%0d alu_a=%h alu_b=%h, required %0d %h %h",
                         i, bus.op_count, bus.alu_a, bus.alu_b, exp_count, ra, rb);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 4'h6; bus.in_b = 4'h7; bus.in_op = 2'd0;
        @(negedge clk);
        bus.in_a = 4'h2; bus.in_b = 4'h9; bus.in_op = 2'd1;
        @(negedge clk);
        held = observed();
        checks++;
        if (held !== ref_op(6, 7, 0)) begin
            errors++;
            $display("FAIL bp_first_result: got %h, required %h", held, ref_op(6, 7, 0));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || observed() !== held ||
                bus.op_count !== exp_count[7:0] || bus.alu_a !== 4'h6) begin
                errors++;
                $display("FAIL bp_hold%0d: in_ready=%b valid=%b res=%h count=%0d alu_a=%h, required 0 1 %h %0d 6",
                         i, bus.in_ready, bus.out_valid, observed(), bus.op_count, bus.alu_a, held, exp_count);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_turnaround_ready: got %b, required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        exp_count++;
        checks++;
        if (bus.op_count !== exp_count[7:0] || bus.out_valid !== 1'b0 ||
            bus.alu_a !== 4'h2 || bus.alu_op !== 2'd1) begin
            errors++;
            $display("FAIL bp_accept: count=%0d valid=%b alu_a=%h alu_op=%0d, required %0d 0 2 1",
                     bus.op_count, bus.out_valid, bus.alu_a, bus.alu_op, exp_count);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== ref_op(2, 9, 1)) begin
            errors++;
            $display("FAIL bp_second_result: valid=%b got %h, required 1 %h", bus.out_valid, observed(), ref_op(2, 9, 1));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_count++;
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1; bus.in_a = 4'h4; bus.in_b = 4'h4; bus.in_op = 2'd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.op_count !== 8'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_assert: valid=%b count=%0d in_ready=%b, required 0 0 1",
                     bus.out_valid, bus.op_count, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.op_count !== 8'd0 || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_release%0d: valid=%b count=%0d in_ready=%b, required 0 0 1",
                         i, bus.out_valid, bus.op_count, bus.in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] exp;
        int issued = 0, results = 0, cyc = 0, last = 0;
        bit accepting;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_a = 4'($urandom_range(0, 15));
        bus.in_b = 4'($urandom_range(0, 15));
        bus.in_op = 2'($urandom_range(0, 3));
        while (results < 256 && cyc < 800) begin
            accepting = bus.in_ready && bus.in_valid;
            if (accepting) begin
                q.push_back(ref_op(int'(bus.in_a), int'(bus.in_b), int'(bus.in_op)));
                issued++;
            end
            @(negedge clk);
            cyc++;
            if (accepting) begin
                if (issued < 256) begin
                    bus.in_a = 4'($urandom_range(0, 15));
                    bus.in_b = 4'($urandom_range(0, 15));
                    bus.in_op = 2'($urandom_range(0, 3));
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid === 1'b1) begin
                exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
                checks++;
                if (observed() !== exp) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got %h, required %h", results, observed(), exp);
                end
                if (results > 0) begin
                    checks++;
                    if (cyc - last != 2) begin
                        errors++;
                        $display("FAIL b2b_spacing%0d: got %0d cycles, required 2", results, cyc - last);
                    end
                end
                last = cyc;
                results++;
                if (results == 256) begin
                    checks++;
                    if (bus.op_count !== 8'd255) begin
                        errors++;
                        $display("FAIL b2b_count_255: got %0d, required 255", bus.op_count);
                    end
                end
            end
        end
        checks++;
        if (results != 256) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d results, required 256", results);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.op_count !== 8'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_wrap: count=%0d valid=%b, required 0 0", bus.op_count, bus.out_valid);
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream issue stage for the N-bit two-operand ALU (ADD/SUB/AND/OR, 2-bit op select).
- Accepts operation requests over a valid/ready handshake and registers the operands and op onto the ALU inputs.
- Captures the ALU's combinational result one cycle later and derives the status flags the ALU itself does not produce: zero, negative, carry/borrow, overflow.
- Presents result plus flags downstream over a second valid/ready handshake, with full backpressure.

Parameters:
N, 4, datapath width of operands and result (N >= 2).
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  sequencer can accept a request this cycle
in_a  input  N  operand A
in_b  input  N  operand B
in_op  input  2  00 ADD, 01 SUB, 10 AND, 11 OR
alu_a  output  N  registered operand A to ALU
alu_b  output  N  registered operand B to ALU
alu_op  output  2  registered op select to ALU
alu_result  input  N  ALU combinational result
out_valid  output  1  result/flags valid
out_ready  input  1  downstream accepts result
out_result  output  N  captured result
out_zero  output  1  result == 0
out_neg  output  1  result[N-1]
out_carry  output  1  ADD: carry-out; SUB: borrow (A < B unsigned); logic ops: 0
out_ovf  output  1  signed overflow for ADD/SUB; logic ops: 0
op_count  output  CNT_W  number of completed output handshakes, wraps

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except in_ready, which is 1 in IDLE; alu_a/alu_b/alu_op = 0; op_count = 0.
- FSM states IDLE, EXEC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch in_a/in_b/in_op into alu_a/alu_b/alu_op, then go to EXEC.
- EXEC:
  - in_ready = 0.
  - alu_result is settled from the registered operands.
  - On the edge: capture out_result = alu_result and the flags, set out_valid, go to DONE.
- DONE:
  - out_valid = 1; out_result and flags stay stable until the handshake completes.
  - in_ready = out_ready (same-cycle turnaround).
  - On out_ready & in_valid: drop out_valid, latch the new request, go to EXEC.
  - On out_ready & !in_valid: drop out_valid, go to IDLE.
  - On !out_ready: stay in DONE with everything held; input requests are not accepted.
- Timing: request accepted at edge k, out_valid high after edge k+1. Peak throughput is 1 op per 2 cycles.
- Flags are computed from the registered alu_a/alu_b/alu_op and the captured alu_result:
  - ADD: carry = bit N of ({1'b0,A}+{1'b0,B}); ovf = (A[N-1]==B[N-1]) & (R[N-1]!=A[N-1]).
  - SUB: carry = (A < B) unsigned; ovf = (A[N-1]!=B[N-1]) & (R[N-1]!=A[N-1]).
  - AND/OR: carry = 0, ovf = 0.
  - All ops: zero = (R == 0); neg = R[N-1].
- op_count increments by 1 on each out_valid & out_ready; it wraps from 2^CNT_W-1 to 0.
- Reset mid-operation (EXEC or DONE): the in-flight op is discarded, out_valid drops immediately, op_count is not incremented.
- alu_* outputs keep their last values in IDLE; they are not cleared.

Decomposition:
- Shared package alu_pkg:
  - op constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11;
  - FSM state typedef {IDLE, EXEC, DONE}.
  - The ALU block adopts the same op constants.
- One combinational sub-module, alu_flag_gen (inputs a, b, op, result; outputs zero, neg, carry, ovf), instantiated once in alu_op_sequencer.

Test Plan (N=4, ALU model connected; R = out_result):
- ADD 7+3 -> R=4'hA, neg=1, carry=0, ovf=1, zero=0; out_valid rises 2 edges after acceptance.
- ADD 9+8 -> R=4'h1, carry=1, ovf=1, neg=0.
- SUB 3-5 -> R=4'hE, carry(borrow)=1, ovf=0, neg=1. Then SUB 5-5 -> R=0, zero=1, carry=0.
- AND C&3 -> R=0, zero=1, carry=0, ovf=0. OR C|3 -> R=4'hF, neg=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready=0 throughout, R and flags unchanged, op_count unchanged.
  - Raise out_ready -> new op accepted the same cycle, op_count increments by 1.
- Back-to-back ops with out_ready=1 -> 1 result every 2 cycles; 256 ops -> op_count wraps to 0.
- Assert rst_n low during EXEC -> out_valid=0, in_ready=1 after release, op_count=0, no spurious result.
